// File: rtl/ram_copy_engine_pkg.sv
// Shared constants and FSM encoding for the RAM copy engine.
package ram_copy_engine_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ram_sync.sv
// 32x32 single-port RAM with registered read, used as the engine's memory.
module ram_sync
    import ram_copy_engine_pkg::*;
#(
    parameter int RDEPTH = DEPTH,
    parameter int RAW    = AW,
    parameter int RDW    = DW
) (
    input  logic           clk,
    input  logic [RAW-1:0] address,
    input  logic [RDW-1:0] data_in,
    output logic [RDW-1:0] data_out,
    input  logic           writeOn
);

    logic [RDW-1:0] mem [RDEPTH];

    always_ff @(posedge clk) begin
        if (writeOn) begin
            mem[address] <= data_in;
        end
        data_out <= mem[address];
    end

endmodule

// File: rtl/ram_copy_engine.sv
// Word-by-word RAM-to-RAM copy engine with running XOR checksum.
module ram_copy_engine
    import ram_copy_engine_pkg::*;
#(
    parameter int CDEPTH = DEPTH,
    parameter int CAW    = AW,
    parameter int CDW    = DW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [CAW-1:0] src,
    input  logic [CAW-1:0] dst,
    input  logic [CAW:0]   len,
    output logic           busy,
    output logic           done,
    output logic [CDW-1:0] checksum,
    output logic [CAW-1:0] ram_address,
    output logic [CDW-1:0] ram_wdata,
    output logic           ram_write,
    input  logic [CDW-1:0] ram_rdata
);

    localparam logic [CAW:0] MAXLEN = (CAW+1)'(CDEPTH);

    state_t         state;
    state_t         state_nxt;
    logic [CAW-1:0] src_q;
    logic [CAW-1:0] dst_q;
    logic [CAW:0]   len_q;
    logic [CAW:0]   idx;
    logic [CAW:0]   len_eff;
    logic [CAW:0]   idx_inc;

    // Oversized requests saturate at the RAM size.
    assign len_eff = (len > MAXLEN) ? MAXLEN : len;
    assign idx_inc = idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            checksum <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        src_q    <= src;
                        dst_q    <= dst;
                        len_q    <= len_eff;
                        idx      <= '0;
                        checksum <= '0;
                    end
                end
                ST_WR: begin
                    checksum <= checksum ^ ram_rdata;
                    idx      <= idx_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != ST_IDLE);
        done        = 1'b0;
        ram_address = '0;
        ram_wdata   = '0;
        ram_write   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len_eff == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                ram_address = src_q + idx[CAW-1:0];
                state_nxt   = ST_WR;
            end
            ST_WR: begin
                ram_address = dst_q + idx[CAW-1:0];
                ram_write   = 1'b1;
                ram_wdata   = ram_rdata;
                state_nxt   = (idx_inc == len_q) ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed and random copies checked against an array-based copy model.
module tb_ram_copy_engine;
    import ram_copy_engine_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  src = '0;
    logic [4:0]  dst = '0;
    logic [5:0]  len = '0;
    logic        busy;
    logic        done;
    logic [31:0] checksum;
    logic [4:0]  dut_addr;
    logic [31:0] dut_wdata;
    logic        dut_we;
    logic [31:0] rdata;

    // Bench-side port into the RAM used only for preloading while idle
    logic        tb_own = 1'b0;
    logic [4:0]  tb_addr = '0;
    logic [31:0] tb_data = '0;
    logic        tb_we = 1'b0;
    logic [4:0]  ram_a;
    logic [31:0] ram_d;
    logic        ram_w;

    assign ram_a = tb_own ? tb_addr : dut_addr;
    assign ram_d = tb_own ? tb_data : dut_wdata;
    assign ram_w = tb_own ? tb_we : dut_we;

    ram_copy_engine u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .ram_address(dut_addr),
        .ram_wdata  (dut_wdata),
        .ram_write  (dut_we),
        .ram_rdata  (rdata)
    );

    ram_sync u_ram (
        .clk     (clk),
        .address (ram_a),
        .data_in (ram_d),
        .data_out(rdata),
        .writeOn (ram_w)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_mem [32];
    logic [31:0] model_cs = '0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ram_put(input int a, input logic [31:0] d);
        tb_own = 1'b1;
        tb_addr = a[4:0];
        tb_data = d;
        tb_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_we = 1'b0;
        tb_own = 1'b0;
        model_mem[a] = d;
    endtask

    // Reference: sequential ascending copy of up to 'limit' words
    task automatic model_copy(input int s, input int d, input int l,
                              input int limit);
        int n;
        logic [31:0] w;
        n = (l > 32) ? 32 : l;
        if (n > limit) n = limit;
        model_cs = '0;
        for (int i = 0; i < n; i++) begin
            w = model_mem[(s + i) % 32];
            model_mem[(d + i) % 32] = w;
            model_cs ^= w;
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s mem[%0d]", tag, i), u_ram.mem[i],
                  model_mem[i]);
    endtask

    // Called just after a negedge; start is seen on the next posedge
    task automatic run_copy(input string tag, input int s, input int d,
                            input int l, input bit poke);
        int le;
        int exp_cyc;
        int done_cyc;
        int done_cnt;
        bit wrote;
        bit busy1;
        le = (l > 32) ? 32 : l;
        exp_cyc = 2 * le + 1;
        src = s[4:0];
        dst = d[4:0];
        len = l[5:0];
        start = 1'b1;
        model_copy(s, d, l, 32);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        done_cyc = 0;
        done_cnt = 0;
        wrote = 1'b0;
        busy1 = busy;
        for (int k = 1; k <= 80; k++) begin
            if (dut_we) wrote = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (done_cyc != 0 && k > done_cyc) break;
            if (poke && k == 3) begin
                start = 1'b1;
                src = 5'($urandom);
                dst = 5'($urandom);
                len = 6'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_c1"}, 32'(busy1), 32'd1);
        check({tag, " done_cyc"}, done_cyc, exp_cyc);
        check({tag, " done_cnt"}, done_cnt, 32'd1);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " checksum"}, checksum, model_cs);
        if (le == 0) check({tag, " no_write"}, 32'(wrote), 32'd0);
        check_ram(tag);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst we", 32'(dut_we), 32'd0);
        check("rst addr", 32'(dut_addr), 32'd0);
        check("rst wdata", dut_wdata, 32'd0);
        check("rst cs", checksum, 32'd0);

        @(negedge clk);
        for (int i = 0; i < 32; i++) ram_put(i, $urandom);
        ram_put(4, 32'h11);
        ram_put(5, 32'h22);
        ram_put(6, 32'h44);
        reset = 1'b0;
        run_copy("basic", 4, 20, 3, 1'b0);
        check("basic cs77", checksum, 32'h77);
        repeat (3) @(negedge clk);
        check("cs hold", checksum, 32'h77);

        run_copy("zero", 7, 12, 0, 1'b0);
        check("zero cs0", checksum, 32'd0);

        ram_put(30, 32'hA);
        ram_put(31, 32'hB);
        ram_put(0, 32'hC);
        run_copy("wrap", 30, 8, 3, 1'b0);
        check("wrap m10", u_ram.mem[10], 32'hC);

        for (int i = 0; i < 4; i++) ram_put(i, i + 1);
        run_copy("ovl", 0, 1, 3, 1'b0);
        check("ovl m3", u_ram.mem[3], 32'd1);

        run_copy("poke", 2, 13, 32, 1'b1);

        // Abort during the fifth write cycle
        src = 5'd0;
        dst = 5'd16;
        len = 6'd32;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort in_wr", 32'(dut_we), 32'd1);
        reset = 1'b1;
        #1;
        check("abort we", 32'(dut_we), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort addr", 32'(dut_addr), 32'd0);
        check("abort cs", checksum, 32'd0);
        model_copy(0, 16, 32, 4);
        @(negedge clk);
        check("abort done2", 32'(done), 32'd0);
        reset = 1'b0;
        run_copy("restart", 5, 9, 6, 1'b0);

        run_copy("full", 0, 0, 32, 1'b0);
        run_copy("clamp", $urandom_range(0, 31), $urandom_range(0, 31),
                 45, 1'b0);
        for (int t = 0; t < 6; t++)
            run_copy($sformatf("rnd%0d", t), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 40), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
